// File: rtl/ram_4kx32_ctrl_pkg.sv
// Shared types and default geometry for the 4K x 32 RAM burst controller.
package ram_ctrl_pkg;

  localparam int DEPTH_DEF      = 4096;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int WIDTH_DEF      = 32;

  // Burst controller states.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/ram_4kx32_ctrl_if.sv
// Command, write-stream and read-stream handshakes of the RAM burst controller.
interface ram_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WIDTH      = WIDTH_DEF
) ();

  // Burst command.
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH:0]   cmd_len;

  // Write stream into the controller.
  logic [WIDTH-1:0]      wr_data;
  logic                  wr_valid;
  logic                  wr_ready;

  // Read stream out of the controller.
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  rd_ready;

  // Requester side: issues commands, supplies write words, consumes read words.
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_data, wr_valid,
    output rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_data, wr_valid,
    input  rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid
  );

endinterface

// File: rtl/ram_4kx32_ctrl_rd_skid_buf.sv
// Two-entry FIFO that catches registered RAM read data so the read stream
// can stall without losing words already in flight.
module rd_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push_en;
  logic             pop_en;

  // A pop on an empty buffer is ignored; a push into a full buffer is only
  // taken when a pop frees a slot in the same cycle.
  assign pop_en  = pop && (count_q != 2'd0);
  assign push_en = push && ((count_q != 2'd2) || pop_en);

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_en) wr_ptr_q <= ~wr_ptr_q;
      if (pop_en)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_en) - 2'(pop_en);
    end
  end

  // Data storage written on push.
  // NOTE: storage is deliberately not reset; the count gates whether it is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/ram_4kx32_ctrl.sv
// Burst controller in front of a single-port synchronous RAM with a one-cycle
// registered read. Write bursts stream straight into the RAM; read bursts
// issue addresses as fast as a two-entry skid buffer can absorb the data.
module ram_4kx32_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WIDTH      = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_ctrl_if.slave             bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH + 1)'(1);

  // Address increment that wraps at the top of the attached RAM.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;      // next RAM address to write or issue
  logic [ADDR_WIDTH:0]   rem_q;       // words still to write or issue
  logic                  inflight_q;  // a read was issued last cycle; its data lands now
  logic [1:0]            buf_count;
  logic                  wr_take;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  assign wr_take = (state_q == WRITE) && bus.wr_valid;
  assign pop     = bus.rd_valid && bus.rd_ready;

  // Buffer slots committed after this cycle: words held plus the one landing
  // now, minus the one leaving. Counting the pop keeps 1 word/cycle with the
  // consumer always ready while never committing more than two slots.
  assign occ   = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (state_q == READ) && (occ < 3'd2);

  // Burst sequencing: command capture, per-word address/count update, exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q <= bus.cmd_addr;
            rem_q  <= bus.cmd_len;
            if (bus.cmd_len == '0)  state_q <= FIN;
            else if (bus.cmd_write) state_q <= WRITE;
            else                    state_q <= READ;
          end
        end
        WRITE: begin
          if (wr_take) begin
            addr_q <= next_addr(addr_q);
            rem_q  <= rem_q - LEN_ONE;
            if (rem_q == LEN_ONE) state_q <= FIN;
          end
        end
        READ: begin
          if (issue) begin
            addr_q <= next_addr(addr_q);
            rem_q  <= rem_q - LEN_ONE;
            if (rem_q == LEN_ONE) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Last word leaves when it is the only one held and nothing lands.
          if (pop && (buf_count == 2'd1) && !inflight_q) state_q <= FIN;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_rd_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .push_data  (ram_rdata),
    .pop        (pop),
    .head_data  (bus.rd_data),
    .head_valid (bus.rd_valid),
    .count      (buf_count)
  );

  // Handshake and status outputs decode the state register directly; only
  // the RAM write strobe and data follow the write stream in the same cycle.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WRITE);
  assign ram_addr      = addr_q;
  assign ram_we        = wr_take;
  assign ram_wdata     = (state_q == WRITE) ? bus.wr_data : '0;
  assign busy          = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
  assign done          = (state_q == FIN);

endmodule

// File: tb/tb_ram_4kx32_ctrl.sv
// Self-checking bench for ram_4kx32_ctrl with a behavioural registered-read RAM.
module tb_ram_4kx32_ctrl;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int W     = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;
  logic          busy;
  logic          done;

  ram_ctrl_if #(.ADDR_WIDTH(AW), .WIDTH(W)) bus ();

  ram_4kx32_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Attached RAM: synchronous write, registered read.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: values seen here are the ones the next edge captures.
  logic [W-1:0]  rd_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [W-1:0]  wr_data_log[$];
  int            done_cnt = 0;
  int            we_cnt = 0;
  int            busy_cnt = 0;
  int            last_pop_cyc = 0;
  bit            track_out = 1'b0;
  logic [AW-1:0] track_start = '0;
  int            max_out = 0;

  always @(negedge clk) begin
    logic [AW-1:0] diff;
    int            outstanding;
    if (ram_we) begin
      wr_addr_log.push_back(ram_addr);
      wr_data_log.push_back(ram_wdata);
      we_cnt++;
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (track_out && busy) begin
      diff        = ram_addr - track_start;
      outstanding = int'(diff) - rd_log.size();
      if (outstanding > max_out) max_out = outstanding;
    end
    if (bus.rd_valid && bus.rd_ready) begin
      rd_log.push_back(bus.rd_data);
      last_pop_cyc = cyc;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_mem [DEPTH];

  // Offer a command and return one cycle after it is taken.
  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [AW:0] l);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    #1;
    while (!bus.cmd_ready && n < 50) begin
      cycle();
      n++;
    end
    check("cmd_accept_in_budget", 64'(n < 50), 64'd1);
    cycle();
    bus.cmd_valid = 1'b0;
  endtask

  // Stream n words base+i, with one idle cycle after word 1 for longer bursts.
  task automatic write_words(input logic [AW-1:0] a, input logic [AW:0] n, input logic [W-1:0] base);
    logic [AW-1:0] ea;
    for (int i = 0; i < int'(n); i++) begin
      int k = 0;
      while (!bus.wr_ready && k < 20) begin
        cycle();
        k++;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = base + W'(i);
      ea           = a + AW'(i);
      exp_mem[ea]  = base + W'(i);
      cycle();
      if (i == 1 && n > 2) begin
        bus.wr_valid = 1'b0;
        #1;
        check("wr_stall_we_low", 64'(ram_we), 64'd0);
        cycle();
      end
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 6000) begin
      cycle();
      n++;
    end
    cycle();
    cycle();
    check(name, 64'(done_cnt - d0), 64'd1);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    logic [W-1:0]  base;   // word i is base+i
  } vec_t;

  task automatic run_vec(input vec_t v);
    int            d0;
    logic [AW-1:0] ea;
    logic [W-1:0]  got;
    d0 = done_cnt;
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    bus.rd_ready = 1'b1;
    do_cmd(v.wr, v.addr, v.len);
    if (v.wr) write_words(v.addr, v.len, v.base);
    wait_done(d0, "vec_done_pulses");
    if (v.wr) begin
      check("vec_wr_count", 64'(wr_addr_log.size()), 64'(v.len));
      for (int i = 0; i < int'(v.len); i++) begin
        ea = v.addr + AW'(i);
        check($sformatf("vec_wr_addr[%0d]", i),
              64'((i < wr_addr_log.size()) ? wr_addr_log[i] : ~ea), 64'(ea));
        check($sformatf("vec_wr_data[%0d]", i),
              64'((i < wr_data_log.size()) ? wr_data_log[i] : 32'hDEAD_DEAD), 64'(v.base + W'(i)));
      end
    end else begin
      check("vec_rd_count", 64'(rd_log.size()), 64'(v.len));
      for (int i = 0; i < int'(v.len); i++) begin
        got = (i < rd_log.size()) ? rd_log[i] : 32'hDEAD_DEAD;
        check($sformatf("vec_rd_data[%0d]", i), 64'(got), 64'(v.base + W'(i)));
      end
    end
    check("vec_busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t          vecs [6];
    int            d0;
    int            we0;
    int            b0;
    int            bad;
    int            first_cyc;
    int            n;
    logic [AW-1:0] ea;

    vecs[0] = '{wr: 1'b1, addr: 12'h010, len: 13'd4, base: 32'h0000_00A0};
    vecs[1] = '{wr: 1'b0, addr: 12'h010, len: 13'd4, base: 32'h0000_00A0};
    vecs[2] = '{wr: 1'b1, addr: 12'hFFE, len: 13'd4, base: 32'h0000_00C0};
    vecs[3] = '{wr: 1'b0, addr: 12'hFFE, len: 13'd4, base: 32'h0000_00C0};
    vecs[4] = '{wr: 1'b1, addr: 12'h100, len: 13'd8, base: 32'h0000_00B0};
    vecs[5] = '{wr: 1'b0, addr: 12'h100, len: 13'd8, base: 32'h0000_00B0};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;

    // Reset state.
    repeat (3) cycle();
    rst_n = 1'b1;
    #1;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_wr_ready",  64'(bus.wr_ready),  64'd0);
    check("rst_rd_valid",  64'(bus.rd_valid),  64'd0);
    check("rst_ram_we",    64'(ram_we),        64'd0);
    check("rst_ram_addr",  64'(ram_addr),      64'd0);
    check("rst_ram_wdata", 64'(ram_wdata),     64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_done",      64'(done),          64'd0);
    cycle();

    // Fill the whole RAM with one DEPTH-long write burst (also covers wrap).
    d0 = done_cnt;
    wr_addr_log.delete();
    do_cmd(1'b1, 12'h000, 13'd4096);
    write_words(12'h000, 13'd4096, 32'h5000_0000);
    wait_done(d0, "fill_done_pulses");
    check("fill_wr_count", 64'(wr_addr_log.size()), 64'd4096);
    bad = 0;
    for (int i = 0; i < wr_addr_log.size(); i++)
      if (wr_addr_log[i] != AW'(i)) bad++;
    check("fill_addr_mismatches", 64'(bad), 64'd0);

    // Directed burst table.
    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Read latency: first address the cycle after accept, data two later.
    d0 = done_cnt;
    rd_log.delete();
    bus.rd_ready = 1'b1;
    do_cmd(1'b0, 12'h010, 13'd2);
    check("lat_ram_addr", 64'(ram_addr), 64'h010);
    check("lat_busy", 64'(busy), 64'd1);
    check("lat_rd_valid_c1", 64'(bus.rd_valid), 64'd0);
    cycle();
    check("lat_rd_valid_c2", 64'(bus.rd_valid), 64'd0);
    cycle();
    check("lat_rd_valid_c3", 64'(bus.rd_valid), 64'd1);
    check("lat_rd_data_c3", 64'(bus.rd_data), 64'h0A0);
    wait_done(d0, "lat_done_pulses");
    check("lat_rd_count", 64'(rd_log.size()), 64'd2);

    // Zero-length command with a stray write word offered.
    d0  = done_cnt;
    we0 = we_cnt;
    b0  = busy_cnt;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hFFFF_FFFF;
    do_cmd(1'b1, 12'h020, 13'd0);
    check("len0_done_now", 64'(done), 64'd1);
    check("len0_busy_now", 64'(busy), 64'd0);
    cycle();
    check("len0_done_next", 64'(done), 64'd0);
    check("len0_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bus.wr_valid = 1'b0;
    cycle();
    check("len0_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("len0_no_we", 64'(we_cnt - we0), 64'd0);
    check("len0_no_busy", 64'(busy_cnt - b0), 64'd0);

    // Consumer stall of 5 cycles mid-burst.
    d0 = done_cnt;
    rd_log.delete();
    max_out     = 0;
    track_start = 12'h100;
    track_out   = 1'b1;
    bus.rd_ready = 1'b1;
    do_cmd(1'b0, 12'h100, 13'd8);
    repeat (3) cycle();
    bus.rd_ready = 1'b0;
    repeat (5) cycle();
    bus.rd_ready = 1'b1;
    wait_done(d0, "stall_done_pulses");
    track_out = 1'b0;
    check("stall_max_outstanding", 64'(max_out), 64'd2);
    check("stall_rd_count", 64'(rd_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("stall_rd_data[%0d]", i),
            64'((i < rd_log.size()) ? rd_log[i] : 32'hDEAD_DEAD), 64'(32'h0B0 + i));

    // Reset while word 3 of 8 is on offer.
    d0 = done_cnt;
    rd_log.delete();
    do_cmd(1'b0, 12'h100, 13'd8);
    n = 0;
    while (rd_log.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    check("rst_mid_reached_word3", 64'(rd_log.size()), 64'd2);
    check("rst_mid_word3_valid", 64'(bus.rd_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    check("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    run_vec(vecs[1]);

    // Full-depth read at one word per cycle.
    d0 = done_cnt;
    rd_log.delete();
    bus.rd_ready = 1'b1;
    do_cmd(1'b0, 12'h000, 13'd4096);
    first_cyc = cyc;
    wait_done(d0, "full_done_pulses");
    check("full_rd_count", 64'(rd_log.size()), 64'd4096);
    bad = 0;
    for (int i = 0; i < rd_log.size(); i++) begin
      ea = AW'(i);
      if (rd_log[i] !== exp_mem[ea]) bad++;
    end
    check("full_rd_data_mismatches", 64'(bad), 64'd0);
    check("full_rd_cycles", 64'(last_pop_cyc - first_cyc + 1), 64'd4098);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
